// File: rtl/fetch_unit_fl_if.sv
// Bus between the fetch unit, the instruction memory and the decoder.
// The fetch unit takes the master side; memory, decoder and interrupt sources sit on the slave side.
interface fetch_unit_fl_if #(
  parameter int MINSTW = 9,
  parameter int NBOPCO = 6,
  parameter int NBOPER = 9,
  parameter int NITR   = 4
);
  logic [NBOPCO+NBOPER-1:0] instr;
  logic [MINSTW-1:0]        instr_addr;
  logic                     acc_zero;
  logic                     stall;
  logic [NITR-1:0]          itr;
  logic [NITR-1:0]          itr_ack;
  logic [NBOPCO-1:0]        opcode;
  logic [NBOPER-1:0]        operand;
  logic                     op_valid;
  logic                     in_isr;
  logic                     stk_ovf;
  logic                     stk_unf;

  modport master (
    input  instr, acc_zero, stall, itr,
    output instr_addr, itr_ack, opcode, operand, op_valid, in_isr, stk_ovf, stk_unf
  );

  modport slave (
    output instr, acc_zero, stall, itr,
    input  instr_addr, itr_ack, opcode, operand, op_valid, in_isr, stk_ovf, stk_unf
  );
endinterface

// File: rtl/fetch_unit_fl.sv
// Instruction front end: PC, sync-read fetch, jumps, call/return stack and
// prioritised vectored interrupts; non-control words go to the decoder via a register stage.
module fetch_unit_fl #(
  parameter int MINSTW  = 9,
  parameter int NBOPCO  = 6,
  parameter int NBOPER  = 9,
  parameter int SDEPTH  = 8,
  parameter int NITR    = 4,
  parameter int ITRBASE = 1,
  parameter int OPJMP   = 11,
  parameter int OPJIZ   = 12,
  parameter int OPCAL   = 13,
  parameter int OPRET   = 14,
  parameter int OPRTI   = 15
) (
  input  logic               clk,
  input  logic               rst,
  fetch_unit_fl_if.master    bus
);
  localparam int NBINST = NBOPCO + NBOPER;
  localparam int AW     = $clog2(SDEPTH);
  localparam int SPW    = AW + 1;
  localparam int IDXW   = (NITR > 1) ? $clog2(NITR) : 1;

  localparam logic [NBOPCO-1:0] JMP_C = NBOPCO'(OPJMP);
  localparam logic [NBOPCO-1:0] JIZ_C = NBOPCO'(OPJIZ);
  localparam logic [NBOPCO-1:0] CAL_C = NBOPCO'(OPCAL);
  localparam logic [NBOPCO-1:0] RET_C = NBOPCO'(OPRET);
  localparam logic [NBOPCO-1:0] RTI_C = NBOPCO'(OPRTI);

  logic [MINSTW-1:0] pc, faddr;
  logic              fvalid;
  logic [MINSTW-1:0] stack [SDEPTH];
  logic [SPW-1:0]    sp;
  logic [NITR-1:0]   pend, itr_q, ack_q;
  logic              in_isr_q, op_valid_q, ovf_q, unf_q;
  logic [NBOPCO-1:0] opcode_q;
  logic [NBOPER-1:0] operand_q;
  logic              hold_q;
  logic [NBINST-1:0] word_q;

  logic [NBINST-1:0] word;
  logic [NBOPCO-1:0] op;
  logic [NBOPER-1:0] opr;
  logic [MINSTW-1:0] target, pc_nxt, push_val, pop_val;
  logic              is_ctrl, redirect, push, pop, rti, take, issue;
  logic              stk_full, stk_empty;
  logic [AW-1:0]     sp_top, sp_pop;
  logic [IDXW-1:0]   idx;
  logic [NITR-1:0]   ack_nxt, ack_out;

  assign stk_full  = (sp == SPW'(SDEPTH));
  assign stk_empty = (sp == '0);
  assign sp_top    = sp[AW-1:0];
  assign sp_pop    = AW'(sp - SPW'(1));
  assign pop_val   = stack[sp_pop];
  assign ack_out   = bus.stall ? '0 : ack_q;

  // While stalled the memory keeps reading the held pc, so the word that belongs
  // to faddr is captured on the first stall cycle and replayed on release.
  always_comb begin
    word     = hold_q ? word_q : bus.instr;
    op       = word[NBINST-1:NBOPER];
    opr      = word[NBOPER-1:0];
    target   = opr[MINSTW-1:0];
    pc_nxt   = pc + MINSTW'(1);
    push_val = faddr + MINSTW'(1);
    is_ctrl  = 1'b0;
    redirect = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    rti      = 1'b0;
    idx      = '0;
    ack_nxt  = '0;
    if (fvalid) begin
      case (op)
        JMP_C: begin
          is_ctrl  = 1'b1;
          redirect = 1'b1;
          pc_nxt   = target;
        end
        JIZ_C: begin
          is_ctrl = 1'b1;
          if (bus.acc_zero) begin
            redirect = 1'b1;
            pc_nxt   = target;
          end
        end
        CAL_C: begin
          is_ctrl  = 1'b1;
          redirect = 1'b1;
          push     = 1'b1;
          pc_nxt   = target;
        end
        RET_C, RTI_C: begin
          is_ctrl  = 1'b1;
          redirect = 1'b1;
          pop      = 1'b1;
          rti      = (op == RTI_C);
          pc_nxt   = stk_empty ? '0 : pop_val;
        end
        default: ;
      endcase
    end
    for (int i = NITR - 1; i >= 0; i--) begin
      if (pend[i]) idx = IDXW'(i);
    end
    // The interrupted word is pushed unissued so OPRTI refetches it.
    take = (|pend) && !in_isr_q && fvalid && !is_ctrl && !stk_full;
    if (take) begin
      redirect     = 1'b1;
      push         = 1'b1;
      push_val     = faddr;
      pc_nxt       = MINSTW'(ITRBASE) + MINSTW'(idx);
      ack_nxt[idx] = 1'b1;
    end
    issue = fvalid && !is_ctrl && !take;
  end

  always_ff @(posedge clk) begin
    if (!rst && !bus.stall && push && !stk_full) stack[sp_top] <= push_val;
  end

  always_ff @(posedge clk) begin
    itr_q <= bus.itr;
    if (rst) begin
      pc         <= '0;
      faddr      <= '0;
      fvalid     <= 1'b0;
      sp         <= '0;
      pend       <= '0;
      ack_q      <= '0;
      in_isr_q   <= 1'b0;
      op_valid_q <= 1'b0;
      opcode_q   <= '0;
      operand_q  <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      hold_q     <= 1'b0;
      word_q     <= '0;
    end else begin
      pend   <= (pend & ~ack_out) | (bus.itr & ~itr_q);
      hold_q <= bus.stall;
      if (bus.stall && !hold_q) word_q <= bus.instr;
      if (!bus.stall) begin
        ack_q  <= take ? ack_nxt : '0;
        faddr  <= pc;
        fvalid <= !redirect;
        pc     <= pc_nxt;
        if (push) begin
          if (stk_full) ovf_q <= 1'b1;
          else          sp    <= sp + SPW'(1);
        end
        if (pop) begin
          if (stk_empty) unf_q <= 1'b1;
          else           sp    <= sp - SPW'(1);
        end
        if (take)     in_isr_q <= 1'b1;
        else if (rti) in_isr_q <= 1'b0;
        op_valid_q <= issue;
        if (issue) begin
          opcode_q  <= op;
          operand_q <= opr;
        end
      end
    end
  end

  assign bus.instr_addr = pc;
  assign bus.itr_ack    = ack_out;
  assign bus.opcode     = opcode_q;
  assign bus.operand    = operand_q;
  assign bus.op_valid   = op_valid_q;
  assign bus.in_isr     = in_isr_q;
  assign bus.stk_ovf    = ovf_q;
  assign bus.stk_unf    = unf_q;
endmodule
